hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the RV32I 5-stage core. It keeps its own copy of the destination/source register tags as they move through ID→EX→MEM→WB. From these tags it drives the 2-bit select of the two EX-stage operand 3:1 muxes (regfile / WB result / MEM result). It also detects load-use hazards, asks the pipeline to stall and insert a bubble, and counts stall cycles for performance monitoring.

## Interface

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  5  ID source register numbers
- id_uses_rs1, id_uses_rs2  in  1  instruction reads rs1/rs2
- id_rd  in  5  ID destination register
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- flush  in  1  taken branch/jump redirect; kills the instruction in ID
- stall_if_id  out  1  hold PC and IF/ID register this cycle
- bubble_ex  out  1  load a NOP into ID/EX this cycle
- fwd_a_sel, fwd_b_sel  out  2  EX operand mux select: 00 regfile, 01 WB result, 10 MEM (EX/MEM ALU) result; 11 never driven
- stall_count  out  CNT_W  number of cycles with stall_if_id=1, saturating

## Operation

- Internal tag registers:
  - EX stage: valid, rs1, rs2, uses_rs1, uses_rs2, rd, reg_write, mem_read
  - MEM and WB stages: valid, rd, reg_write
- Load-use hazard (combinational), `lu`, is true when all of these hold:
  - ex_valid & ex_mem_read & ex_rd≠0 & id_valid
  - and either (id_uses_rs1 & id_rs1==ex_rd) or (id_uses_rs2 & id_rs2==ex_rd)
- stall_if_id = lu & ~flush. Flush has priority because the stalled instruction is being killed anyway.
- bubble_ex = lu | flush.
- Tag update each clock, when not in reset:
  - MEM←EX and WB←MEM always advance; the MEM/WB stages never stall.
  - EX←ID tags with ex_valid=id_valid, but only if bubble_ex=0.
  - If bubble_ex=1, ex_valid←0 and the other EX fields are don't-care.
- Forwarding for operand A, computed from registered tags only (no input→output path):
  - 10 if ex_uses_rs1 & mem_valid & mem_reg_write & mem_rd≠0 & mem_rd==ex_rs1
  - else 01 if ex_uses_rs1 & wb_valid & wb_reg_write & wb_rd≠0 & wb_rd==ex_rs1
  - else 00
  - Operand B is identical using rs2/uses_rs2.
  - MEM beats WB (youngest producer wins).
  - x0 is never forwarded.
  - If ex_valid=0, both selects are 00.
- A load in MEM is never forwarded through 10. The load-use stall guarantees the consumer sees the load in WB and so uses 01.
- stall_count increments by 1 on each clock edge where stall_if_id=1. It holds at 2^CNT_W−1 once reached.

## Timing

- Reset (rst=1 at a clock edge):
  - all valid bits 0, stall_count 0
  - next cycle: fwd_a_sel=fwd_b_sel=00, stall_if_id=0, bubble_ex=flush
- Reset during a stall clears the hazard within that edge. stall_if_id is 0 in the following cycle unless a new load enters EX.
- Load-use stall lasts exactly one cycle per hazard:
  - Cycle N: load in EX, consumer in ID → stall_if_id=1, bubble_ex=1.
  - Cycle N+1: load in MEM, bubble in EX, consumer still in ID → no stall.
  - Cycle N+2: consumer in EX with sel=01.
- Selects are valid combinationally, in the same cycle the instruction occupies EX. They change only after a clock edge.
- Back-to-back dependent ALU ops: no stall; sel=10 on the second op.
- Simultaneous flush and lu: stall_if_id=0, bubble_ex=1; the count does not increment.
- A consumer with both operands matching the load gives one stall, not two.

## Test plan

- Reset: assert rst 2 cycles with random inputs.
  - Required: stall_count=0, sels=00, stall_if_id=0.
- ALU chain: add x5 then sub x6,x5,x5 in consecutive cycles.
  - Required: when sub is in EX, fwd_a_sel=fwd_b_sel=10; one cycle later, with an independent op using x5 in EX, sel=01.
- Load-use: lw x7 followed by add x8,x7,x1.
  - Required: exactly one cycle with stall_if_id=1 and bubble_ex=1; then fwd_a_sel=01, fwd_b_sel=00; stall_count=1.
- x0 and priority:
  - Producers write x0, then a consumer of x0: sels stay 00.
  - MEM and WB both hold rd=x3: sel=10.
- Flush during hazard: lw x9 in EX, a consumer of x9 in ID, flush=1.
  - Required: stall_if_id=0, bubble_ex=1, stall_count unchanged, and the consumer never reaches EX.
- Saturation: with CNT_W=4, force 20 load-use stalls.
  - Required: stall_count sticks at 15.

Source files
------------

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: pipeline<->hazard controller bus; master drives ID tags and flush, slave returns stall, bubble, forward selects, stall count
interface hazard_fwd_ctrl_if #(
  parameter int CNT_W = 16
);
  logic id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic id_uses_rs1;
  logic id_uses_rs2;
  logic [4:0] id_rd;
  logic id_reg_write;
  logic id_mem_read;
  logic flush;
  logic stall_if_id;
  logic bubble_ex;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, id_mem_read, flush,
    input stall_if_id, bubble_ex, fwd_a_sel, fwd_b_sel, stall_count
  );
  modport slave (
    input id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, id_mem_read, flush,
    output stall_if_id, bubble_ex, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall/bubble, EX operand forward selects from EX/MEM/WB tags, saturating stall counter; ports clk, rst, h (slave bus)
module hazard_fwd_ctrl #(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_fwd_ctrl_if.slave h
);
  logic ex_valid;
  logic ex_uses_rs1;
  logic ex_uses_rs2;
  logic ex_reg_write;
  logic ex_mem_read;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic mem_valid;
  logic mem_reg_write;
  logic [4:0] mem_rd;
  logic wb_valid;
  logic wb_reg_write;
  logic [4:0] wb_rd;
  logic [CNT_W-1:0] cnt;
  logic lu;
  function automatic logic [1:0] fwd(input logic uses, input logic [4:0] rs);
    return !(ex_valid && uses && rs != 5'd0) ? 2'b00 :
           (mem_valid && mem_reg_write && mem_rd == rs) ? 2'b10 :
           (wb_valid && wb_reg_write && wb_rd == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    lu = ex_valid && ex_mem_read && ex_rd != 5'd0 && h.id_valid &&
         ((h.id_uses_rs1 && h.id_rs1 == ex_rd) || (h.id_uses_rs2 && h.id_rs2 == ex_rd));
    h.stall_if_id = lu && !h.flush;
    h.bubble_ex = lu || h.flush;
    h.fwd_a_sel = fwd(ex_uses_rs1, ex_rs1);
    h.fwd_b_sel = fwd(ex_uses_rs2, ex_rs2);
    h.stall_count = cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid <= 1'b0;
      cnt <= '0;
    end else begin
      ex_valid <= h.id_valid && !h.bubble_ex;
      mem_valid <= ex_valid;
      wb_valid <= mem_valid;
      if (h.stall_if_id && !(&cnt)) cnt <= cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    ex_rs1 <= h.id_rs1;
    ex_rs2 <= h.id_rs2;
    ex_uses_rs1 <= h.id_uses_rs1;
    ex_uses_rs2 <= h.id_uses_rs2;
    ex_rd <= h.id_rd;
    ex_reg_write <= h.id_reg_write;
    ex_mem_read <= h.id_mem_read;
    mem_rd <= ex_rd;
    mem_reg_write <= ex_reg_write;
    wb_rd <= mem_rd;
    wb_reg_write <= mem_reg_write;
  end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: scoreboard bench for hazard_fwd_ctrl with CNT_W=4
module tb_hazard_fwd_ctrl;
  typedef struct packed {
    logic v;
    logic [4:0] r1;
    logic [4:0] r2;
    logic u1;
    logic u2;
    logic [4:0] rd;
    logic rw;
    logic mr;
    logic fl;
  } stim_t;
  localparam stim_t NOP = '0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [9:0] sb[$];
  hazard_fwd_ctrl_if #(.CNT_W(4)) bus();
  hazard_fwd_ctrl #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .h(bus));
  always #5 clk = ~clk;
  function automatic stim_t mk(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                               input logic u2, input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    return '{v: v, r1: r1, r2: r2, u1: u1, u2: u2, rd: rd, rw: rw, mr: mr, fl: fl};
  endfunction
  function automatic logic [9:0] ev(input logic st, input logic bu, input logic [1:0] a, input logic [1:0] b,
                                    input logic [3:0] c);
    return {st, bu, a, b, c};
  endfunction
  function automatic logic [9:0] obs();
    return {bus.stall_if_id, bus.bubble_ex, bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_count};
  endfunction
  task automatic drive(input stim_t s);
    bus.id_valid = s.v;
    bus.id_rs1 = s.r1;
    bus.id_rs2 = s.r2;
    bus.id_uses_rs1 = s.u1;
    bus.id_uses_rs2 = s.u2;
    bus.id_rd = s.rd;
    bus.id_reg_write = s.rw;
    bus.id_mem_read = s.mr;
    bus.flush = s.fl;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(NOP);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset();
    stim_t s[4];
    logic [9:0] e[4];
    logic r[4];
    logic [31:0] x;
    logic [9:0] got;
    logic [9:0] want;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x = $urandom;
      drive(x[20:0]);
      @(posedge clk);
      #1;
    end
    s = '{NOP, mk(1,2,0,1,0,7,1,1,0), mk(1,7,1,1,1,8,1,0,0), mk(1,7,1,1,1,8,1,0,0)};
    r = '{1'b0, 1'b0, 1'b1, 1'b0};
    e = '{ev(0,0,0,0,0), ev(0,0,0,0,0), ev(1,1,0,0,0), ev(0,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      rst = r[i];
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clk);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask
  task automatic test_alu_chain();
    stim_t s[5];
    logic [9:0] e[5];
    logic [9:0] got;
    logic [9:0] want;
    do_reset();
    s = '{mk(1,1,2,1,1,5,1,0,0), mk(1,5,5,1,1,6,1,0,0), mk(1,5,9,1,1,7,1,0,0), NOP, NOP};
    e = '{ev(0,0,0,0,0), ev(0,0,0,0,0), ev(0,0,2,2,0), ev(0,0,1,0,0), ev(0,0,0,0,0)};
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clk);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL alu_chain[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_load_use();
    stim_t s[5];
    logic [9:0] e[5];
    logic [9:0] got;
    logic [9:0] want;
    do_reset();
    s = '{mk(1,2,0,1,0,7,1,1,0), mk(1,7,1,1,1,8,1,0,0), mk(1,7,1,1,1,8,1,0,0), NOP, NOP};
    e = '{ev(0,0,0,0,0), ev(1,1,0,0,0), ev(0,0,0,0,1), ev(0,0,1,0,1), ev(0,0,0,0,1)};
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clk);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_x0_priority();
    stim_t s[14];
    logic [9:0] e[14];
    logic [9:0] got;
    logic [9:0] want;
    do_reset();
    s = '{mk(1,1,0,1,0,0,1,0,0), mk(1,2,0,1,0,0,1,0,0), mk(1,0,0,1,1,4,1,0,0), NOP,
          mk(1,1,0,1,0,0,1,1,0), mk(1,0,0,1,1,4,1,0,0), NOP, mk(1,1,2,1,1,3,1,0,0),
          mk(1,4,5,1,1,3,1,0,0), mk(1,3,3,1,1,10,1,0,0), NOP, mk(1,1,2,1,1,3,0,0,0),
          mk(1,3,0,1,0,0,1,0,0), NOP};
    for (int i = 0; i < 14; i++) e[i] = (i == 10) ? ev(0,0,2,2,0) : ev(0,0,0,0,0);
    for (int i = 0; i < 14; i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clk);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL x0_priority[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_flush_hazard();
    stim_t s[6];
    logic [9:0] e[6];
    logic [9:0] got;
    logic [9:0] want;
    do_reset();
    s = '{mk(1,2,0,1,0,9,1,1,0), mk(1,9,9,1,1,11,1,0,1), NOP, NOP, mk(1,9,9,1,1,11,1,0,1), NOP};
    e = '{ev(0,0,0,0,0), ev(0,1,0,0,0), ev(0,0,0,0,0), ev(0,0,0,0,0), ev(0,1,0,0,0), ev(0,0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clk);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL flush_hazard[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_back_to_back();
    stim_t s[8];
    logic [9:0] e[8];
    logic [9:0] got;
    logic [9:0] want;
    do_reset();
    s = '{mk(1,2,0,1,0,7,1,1,0), mk(1,7,7,1,1,8,1,0,0), mk(1,7,7,1,1,8,1,0,0), mk(1,8,0,1,0,12,1,1,0),
          mk(1,1,12,1,1,13,1,0,0), mk(1,1,12,1,1,13,1,0,0), NOP, NOP};
    e = '{ev(0,0,0,0,0), ev(1,1,0,0,0), ev(0,0,0,0,1), ev(0,0,1,1,1),
          ev(1,1,2,0,1), ev(0,0,0,0,2), ev(0,0,0,1,2), ev(0,0,0,0,2)};
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      @(negedge clk);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL back_to_back[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_saturation();
    logic [3:0] m;
    logic [9:0] got;
    logic [9:0] want;
    do_reset();
    m = 4'd0;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 3; k++) begin
        drive(k == 0 ? mk(1,2,0,1,0,7,1,1,0) : mk(1,7,1,1,1,8,1,0,0));
        sb.push_back(k == 0 ? ev(0,0,(i > 0) ? 2'b01 : 2'b00,0,m) : k == 1 ? ev(1,1,0,0,m) : ev(0,0,0,0,m));
        @(negedge clk);
        got = obs();
        want = sb.pop_front();
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL saturation[%0d.%0d] got=%b want=%b", i, k, got, want);
        end
        @(posedge clk);
        #1;
        if (k == 1 && m != 4'd15) m = m + 4'd1;
      end
    end
    drive(NOP);
    @(negedge clk);
    total++;
    if (bus.stall_count !== 4'd15) begin
      bad++;
      $display("FAIL saturation_final got=%0d want=15", bus.stall_count);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(NOP);
    @(posedge clk);
    #1;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_x0_priority();
    test_flush_hazard();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
